// File: rtl/regfile_param.sv
// Parametrised general/temporary register file with shared function and wrap flag.
// Optional macro REGFILE_BYPASS_EN forwards next values of enabled registers to read ports.
module regfile_param #(
   parameter int W  = 8,
   parameter int NR = 4,
   parameter int NT = 4,
   parameter int SW = $clog2(NR+NT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  i_data,
   input  logic [1:0]    fun_sel,
   input  logic [NR-1:0] r_sel,
   input  logic [NT-1:0] t_sel,
   input  logic [SW-1:0] o1_sel,
   input  logic [SW-1:0] o2_sel,
   output logic [W-1:0]  o1,
   output logic [W-1:0]  o2,
   output logic          o1_zero,
   output logic          o2_zero,
   output logic          wrap
);

   localparam int N = NR + NT;

   // Unified index: k < NT is T(k+1), k >= NT is R(k-NT+1)
   logic [W-1:0] r_reg [N];
   logic         r_wrap;
   logic [W-1:0] w_nxt [N];
   logic [W-1:0] w_rd  [N];
   logic [N-1:0] w_en;
   logic [N-1:0] w_wrp;
   logic [W-1:0] w_o1;
   logic [W-1:0] w_o2;

   // Map MSB-first select vectors onto the unified index
   always_comb begin
      w_en = '0;
      for (int k = 0; k < NT; k++) w_en[k] = t_sel[NT-1-k];
      for (int j = 0; j < NR; j++) w_en[NT+j] = r_sel[NR-1-j];
   end

   // Shared function result and wrap detection per register
   always_comb begin
      for (int k = 0; k < N; k++) begin
         w_nxt[k] = r_reg[k];
         w_wrp[k] = 1'b0;
         case (fun_sel)
            2'b00: w_nxt[k] = '0;
            2'b01: w_nxt[k] = i_data;
            2'b10: begin
               w_nxt[k] = r_reg[k] - W'(1);
               w_wrp[k] = w_en[k] && (r_reg[k] == '0);
            end
            default: begin
               w_nxt[k] = r_reg[k] + W'(1);
               w_wrp[k] = w_en[k] && (r_reg[k] == '1);
            end
         endcase
      end
   end

   // Register state and one-cycle wrap pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < N; k++) r_reg[k] <= '0;
         r_wrap <= 1'b0;
      end else begin
         for (int k = 0; k < N; k++)
            if (w_en[k]) r_reg[k] <= w_nxt[k];
         r_wrap <= |w_wrp;
      end
   end

   // Per-register read value, optionally forwarding the pending write
   always_comb begin
      for (int k = 0; k < N; k++) begin
`ifdef REGFILE_BYPASS_EN
         w_rd[k] = w_en[k] ? w_nxt[k] : r_reg[k];
`else
         w_rd[k] = r_reg[k];
`endif
      end
   end

   // Read muxes; unmatched selects and reset force zero
   always_comb begin
      w_o1 = '0;
      w_o2 = '0;
      for (int k = 0; k < N; k++) begin
         if (o1_sel == SW'(k)) w_o1 = w_rd[k];
         if (o2_sel == SW'(k)) w_o2 = w_rd[k];
      end
      if (!rst_n) begin
         w_o1 = '0;
         w_o2 = '0;
      end
   end

   assign o1      = w_o1;
   assign o2      = w_o2;
   assign o1_zero = (w_o1 == '0);
   assign o2_zero = (w_o2 == '0);
   assign wrap    = r_wrap;

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised general/temporary register file, the next generation of the fixed 4+4×8-bit register file used in the datapath. It holds `NR` general registers (R1..R`NR`) and `NT` temporary registers (T1..T`NT`) of `W` bits. Every enabled register executes one shared function per clock: clear, load, decrement or increment. Two independent read ports feed the ALU operand muxes, and a registered wrap flag reports counter overflow or underflow.

## Interface
- `W`, 8: register width in bits.
- `NR`, 4: number of general registers, 1..8.
- `NT`, 4: number of temporary registers, 1..8.
- `SW`, derived as $clog2(NR+NT): read-select width; not overridden by instantiators.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `i_data`  in  W  load data.
- `fun_sel`  in  2  shared function: 00 clear, 01 load, 10 decrement, 11 increment.
- `r_sel`  in  NR  general-register write enables, active-high; bit NR-1 = R1, bit 0 = R`NR`.
- `t_sel`  in  NT  temporary-register write enables, active-high; bit NT-1 = T1, bit 0 = T`NT`.
- `o1_sel`, `o2_sel`  in  SW  read selects; value k < NT selects T(k+1), and NT ≤ k < NT+NR selects R(k-NT+1).
- `o1`, `o2`  out  W  read data.
- `o1_zero`, `o2_zero`  out  1  high when the corresponding `o1`/`o2` value is all zeros.
- `wrap`  out  1  registered pulse that flags an increment or decrement wrap.

## Operation
- Register update at posedge `clk`, per register with its enable bit high:
  - clear: 0.
  - load: `i_data`.
  - decrement: value-1, modulo 2^W.
  - increment: value+1, modulo 2^W.
- Registers with the enable low hold their value. R and T enables are independent; any combination, including all bits, may be high in the same cycle, and every selected register receives the same function.
- All-zero `r_sel` and `t_sel`: no state change, and `wrap` goes to 0 on the next edge.
- Read ports are combinational from stored state. Both ports may select the same register.
- An out-of-range select (k ≥ NR+NT) returns 0 on that port, with its zero flag high.
- `wrap` is set to 1 at the posedge where at least one enabled register wraps:
  - increment from all-ones to 0;
  - decrement from 0 to all-ones.
- Otherwise `wrap` is cleared to 0 at that edge, so it is high for exactly one cycle per wrapping edge.
- Clear and load never set `wrap`.

## Timing
- Reset values: every R and T register is 0 and `wrap` is 0. While `rst_n` is low, `o1` and `o2` are 0 and both zero flags are 1.
- Reset assertion takes effect immediately (asynchronous), including in the middle of a burst of increments. No update occurs on the first posedge after deassertion unless an enable is high at that edge.
- Write latency is 1 cycle: a new value is visible on the read ports after the posedge that writes it, unless bypass is compiled in (see Configuration).
- `wrap` is valid in the cycle after the wrapping edge.
- No handshake: an operation is issued every cycle the enables are high.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined:
  - Each read port whose selected register is enabled in the current cycle returns that register's next value (the result of the function), combinationally.
  - The zero flag follows the forwarded value.
- Undefined: read ports always return the stored value.
- Reset behaviour is identical in both builds.

## Test plan
Bench parameters: W=8, NR=4, NT=4, `i_data`=0x04.
- Reset then read: assert `rst_n`=0 mid-cycle -> `o1`=`o2`=0x00 at once, both zero flags 1, `wrap`=0.
- Increment R4 from reset: `o1_sel`=7, `fun_sel`=11, `r_sel`=0001 held 3 cycles -> `o1` shows 0x01, 0x02, 0x03 after successive edges; `o2_sel`=0 (T1) stays 0x00.
- Load then decrement wrap: load 0x04 into T1 (`t_sel`=1000); decrement 5 times -> T1 = 0x03, 0x02, 0x01, 0x00, 0xFF; `wrap`=1 only in the cycle after the 5th edge.
- Broadcast increment: `r_sel`=1111, `t_sel`=1111, `fun_sel`=11 for 2 cycles from reset -> all eight registers read 0x02.
- Clear and select edge cases:
  - clear R2 (`r_sel`=0100) after loading 0x04 -> `o1_sel`=5 reads 0x00 with `o1_zero`=1;
  - an out-of-range select is impossible at NR+NT=8, so repeat with NR=3 and `o1_sel`=7 -> 0x00.
- Bypass (bench built with `REGFILE_BYPASS_EN`): R1 holds 0x04, `o1_sel`=4, increment R1 -> `o1`=0x05 in the same cycle before the edge. Without the macro, `o1`=0x04 until the edge.
